// File: rtl/zmod_adc_capture_v1_0_pkg.sv
// ----------------------------------------------------------------------------
// zmod_pkg : shared constants and capture state encoding for ZMOD ADC capture
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package zmod_pkg;

   localparam int ZMOD_DW      = 14;
   localparam int ZMOD_DEPTH   = 128;
   localparam int ZMOD_AW      = 7;
   localparam int ZMOD_PRETRIG = 16;

   typedef enum logic [2:0] {
      CAP_IDLE    = 3'd0,
      CAP_PREFILL = 3'd1,
      CAP_ARMED   = 3'd2,
      CAP_POST    = 3'd3,
      CAP_DONE    = 3'd4
   } cap_state_t;

endpackage

`default_nettype wire

// File: rtl/zmod_adc_capture_v1_0_ram.sv
// ----------------------------------------------------------------------------
// zmod_capture_ram_v1_0 : simple dual-port sample RAM, sync write, registered read
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module zmod_capture_ram_v1_0 #(
   parameter int DW = 14,
   parameter int AW = 7
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [DW-1:0] i_wr_data,
   input  logic [AW-1:0] i_rd_addr,
   output logic [DW-1:0] o_rd_data
);

   logic [DW-1:0] r_mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Only the output register is reset; the array itself keeps its contents.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         o_rd_data <= '0;
      end else begin
         o_rd_data <= r_mem[i_rd_addr];
      end
   end

endmodule

`default_nettype wire

// File: rtl/zmod_adc_capture_v1_0.sv
// ----------------------------------------------------------------------------
// zmod_adc_capture_v1_0 : triggered pre/post-trigger capture buffer for one ADC channel
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module zmod_adc_capture_v1_0
   import zmod_pkg::*;
#(
   parameter int DEPTH   = ZMOD_DEPTH,
   parameter int AW      = ZMOD_AW,
   parameter int DW      = ZMOD_DW,
   parameter int PRETRIG = ZMOD_PRETRIG
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [DW-1:0] is14_data,
   input  logic          i_valid,
   input  logic          i_arm,
   input  logic          i_abort,
   input  logic [DW-1:0] is14_trig_level,
   input  logic          i_trig_rising,
   input  logic          i_force_trig,
   input  logic [AW-1:0] i7_rd_addr,
   output logic [DW-1:0] os14_rd_data,
   output logic          o_armed,
   output logic          or_triggered,
   output logic          or_done,
   output logic [AW-1:0] or7_trig_index
);

   localparam logic [AW-1:0] C_PRE_LAST  = AW'(PRETRIG - 1);
   localparam logic [AW-1:0] C_PRETRIG   = AW'(PRETRIG);
   localparam logic [AW-1:0] C_POST_LOAD = AW'(DEPTH - PRETRIG - 1);

   cap_state_t    r_state;
   cap_state_t    w_next_state;
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_start_ptr;
   logic [AW-1:0] r_pre_cnt;
   logic [AW-1:0] r_post_cnt;
   logic [DW-1:0] r_prev;
   logic          r_force_pend;
   logic          w_wr_en;
   logic          w_trig;
   logic          w_cross;
   logic [AW-1:0] w_rd_addr;

   assign o_armed   = (r_state == CAP_ARMED);
   assign w_rd_addr = r_start_ptr + i7_rd_addr;

   always_comb begin
      w_next_state = r_state;
      w_wr_en      = 1'b0;
      w_trig       = 1'b0;
      if (i_trig_rising) begin
         w_cross = ($signed(r_prev) < $signed(is14_trig_level)) &&
                   ($signed(is14_data) >= $signed(is14_trig_level));
      end else begin
         w_cross = ($signed(r_prev) > $signed(is14_trig_level)) &&
                   ($signed(is14_data) <= $signed(is14_trig_level));
      end

      if (i_abort) begin
         w_next_state = CAP_IDLE;
      end else begin
         case (r_state)
            CAP_IDLE, CAP_DONE: begin
               if (i_arm) w_next_state = CAP_PREFILL;
            end
            CAP_PREFILL: begin
               if (i_valid) begin
                  w_wr_en = 1'b1;
                  if (r_pre_cnt == C_PRE_LAST) w_next_state = CAP_ARMED;
               end
            end
            CAP_ARMED: begin
               if (i_valid) begin
                  w_wr_en = 1'b1;
                  w_trig  = i_force_trig || r_force_pend || w_cross;
                  if (w_trig) begin
                     w_next_state = (C_POST_LOAD == '0) ? CAP_DONE : CAP_POST;
                  end
               end
            end
            CAP_POST: begin
               if (i_valid) begin
                  w_wr_en = 1'b1;
                  if (r_post_cnt == AW'(1)) w_next_state = CAP_DONE;
               end
            end
            default: w_next_state = CAP_IDLE;
         endcase
      end
   end

   // r_post_cnt holds the number of post-trigger samples still to be written,
   // so the record closes at exactly DEPTH samples and never overwrites index 0.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state        <= CAP_IDLE;
         r_wr_ptr       <= '0;
         r_start_ptr    <= '0;
         r_pre_cnt      <= '0;
         r_post_cnt     <= '0;
         r_prev         <= '0;
         r_force_pend   <= 1'b0;
         or_triggered   <= 1'b0;
         or_done        <= 1'b0;
         or7_trig_index <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_prev   <= is14_data;
         end
         if (i_abort) begin
            r_pre_cnt      <= '0;
            r_post_cnt     <= '0;
            r_force_pend   <= 1'b0;
            or_triggered   <= 1'b0;
            or_done        <= 1'b0;
            or7_trig_index <= '0;
         end else begin
            case (r_state)
               CAP_IDLE, CAP_DONE: begin
                  if (i_arm) begin
                     r_pre_cnt      <= '0;
                     r_force_pend   <= 1'b0;
                     or_triggered   <= 1'b0;
                     or_done        <= 1'b0;
                     or7_trig_index <= '0;
                  end
               end
               CAP_PREFILL: begin
                  if (i_valid) r_pre_cnt <= r_pre_cnt + 1'b1;
               end
               CAP_ARMED: begin
                  if (w_trig) begin
                     r_start_ptr    <= r_wr_ptr - C_PRETRIG;
                     r_post_cnt     <= C_POST_LOAD;
                     r_force_pend   <= 1'b0;
                     or_triggered   <= 1'b1;
                     or7_trig_index <= C_PRETRIG;
                     if (C_POST_LOAD == '0) or_done <= 1'b1;
                  end else if (i_force_trig) begin
                     r_force_pend <= 1'b1;
                  end
               end
               CAP_POST: begin
                  if (i_valid) begin
                     r_post_cnt <= r_post_cnt - 1'b1;
                     if (r_post_cnt == AW'(1)) or_done <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   zmod_capture_ram_v1_0 #(
      .DW (DW),
      .AW (AW)
   ) u_ram (
      .clk       (clk),
      .rstn      (rstn),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (is14_data),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (os14_rd_data)
   );

endmodule

`default_nettype wire

// File: tb/tb_zmod_adc_capture_v1_0.sv
// ----------------------------------------------------------------------------
// tb_zmod_adc_capture_v1_0 : self-checking bench for the ZMOD ADC capture buffer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_zmod_adc_capture_v1_0;

   localparam int DEPTH   = 128;
   localparam int AW      = 7;
   localparam int DW      = 14;
   localparam int PRETRIG = 16;
   localparam int MAXN    = 1500;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [DW-1:0] is14_data = '0;
   logic          i_valid = 1'b0;
   logic          i_arm = 1'b0;
   logic          i_abort = 1'b0;
   logic [DW-1:0] is14_trig_level = '0;
   logic          i_trig_rising = 1'b1;
   logic          i_force_trig = 1'b0;
   logic [AW-1:0] i7_rd_addr = '0;
   logic [DW-1:0] os14_rd_data;
   logic          o_armed;
   logic          or_triggered;
   logic          or_done;
   logic [AW-1:0] or7_trig_index;

   always #5 clk = ~clk;

   zmod_adc_capture_v1_0 #(
      .DEPTH   (DEPTH),
      .AW      (AW),
      .DW      (DW),
      .PRETRIG (PRETRIG)
   ) dut (
      .clk             (clk),
      .rstn            (rstn),
      .is14_data       (is14_data),
      .i_valid         (i_valid),
      .i_arm           (i_arm),
      .i_abort         (i_abort),
      .is14_trig_level (is14_trig_level),
      .i_trig_rising   (i_trig_rising),
      .i_force_trig    (i_force_trig),
      .i7_rd_addr      (i7_rd_addr),
      .os14_rd_data    (os14_rd_data),
      .o_armed         (o_armed),
      .or_triggered    (or_triggered),
      .or_done         (or_done),
      .or7_trig_index  (or7_trig_index)
   );

   // kind: 0 ramp 10*n, 1 sine amplitude 1000 period 50, 2 constant 1234,
   //       3 level crossings at n=5 and n=15 (prefill) and from n=30 on.
   // exp_t is the stream index (from arming) of the expected trigger sample.
   typedef struct {
      int kind;
      int level;
      bit rising;
      bit frc;
      int stride;
      int exp_t;
   } vec_t;

   vec_t vecs[5];
   int   n_cmp = 0;
   int   n_err = 0;
   int   q_exp[$];

   function automatic int gen(int kind, int n);
      case (kind)
         0:       return 10 * n;
         1:       return $rtoi(1000.0 * $sin(6.283185307179586 * n / 50.0));
         2:       return 1234;
         default: return (n == 5 || n == 15 || n >= 30) ? 600 : 0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic send(input int value, input int stride);
      is14_data = DW'(value);
      i_valid   = 1'b1;
      tick();
      i_valid   = 1'b0;
      for (int s = 1; s < stride; s++) tick();
   endtask

   task automatic run_capture(input vec_t v, input string tag);
      int n;
      int cyc;
      int exp_done_n;
      int got;
      exp_done_n      = v.exp_t + DEPTH - PRETRIG - 1;
      is14_trig_level = DW'(v.level);
      i_trig_rising   = v.rising;
      i_force_trig    = v.frc;
      i_arm = 1'b1;
      tick();
      i_arm = 1'b0;
      cyc = 1;
      n = 0;
      while (n < MAXN && !or_done) begin
         send(gen(v.kind, n), v.stride);
         cyc += v.stride;
         if (n == PRETRIG - 2) check({tag, "_armed_early"}, int'(o_armed), 0);
         if (n == PRETRIG - 1) check({tag, "_armed"}, int'(o_armed), 1);
         if (n == exp_done_n - 1) check({tag, "_done_early"}, int'(or_done), 0);
         n++;
      end
      i_force_trig = 1'b0;
      check({tag, "_done_sample"}, n - 1, exp_done_n);
      check({tag, "_latency"}, cyc, 1 + v.stride * (exp_done_n + 1));
      check({tag, "_triggered"}, int'(or_triggered), 1);
      check({tag, "_trig_index"}, int'(or7_trig_index), PRETRIG);
      check({tag, "_armed_off"}, int'(o_armed), 0);
      // The frozen record must ignore anything arriving after completion.
      for (int k = 0; k < 5; k++) send(4321, 1);
      for (int k = 0; k < DEPTH; k++) begin
         i7_rd_addr = AW'(k);
         q_exp.push_back(gen(v.kind, v.exp_t - PRETRIG + k));
         tick();
         got = q_exp.pop_front();
         check($sformatf("%s_rd%0d", tag, k), int'($signed(os14_rd_data)), got);
      end
   endtask

   initial begin
      vecs[0] = '{kind: 0, level:  500, rising: 1'b1, frc: 1'b0, stride: 1, exp_t: 50};
      vecs[1] = '{kind: 1, level: -100, rising: 1'b0, frc: 1'b0, stride: 1, exp_t: 26};
      vecs[2] = '{kind: 2, level:    0, rising: 1'b1, frc: 1'b1, stride: 1, exp_t: 16};
      vecs[3] = '{kind: 0, level:  500, rising: 1'b1, frc: 1'b0, stride: 3, exp_t: 50};
      vecs[4] = '{kind: 3, level:  500, rising: 1'b1, frc: 1'b0, stride: 1, exp_t: 30};

      rstn = 1'b0;
      repeat (3) tick();
      check("rst_rd_data",    int'(os14_rd_data),   0);
      check("rst_triggered",  int'(or_triggered),   0);
      check("rst_done",       int'(or_done),        0);
      check("rst_trig_index", int'(or7_trig_index), 0);
      check("rst_armed",      int'(o_armed),        0);
      rstn = 1'b1;
      repeat (2) tick();

      for (int i = 0; i < 5; i++) run_capture(vecs[i], $sformatf("vec%0d", i));

      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      check("abort_done_clr",  int'(or_done),        0);
      check("abort_trig_clr",  int'(or_triggered),   0);
      check("abort_index_clr", int'(or7_trig_index), 0);

      // Abort while ARMED; arm issued in the same cycle must lose.
      is14_trig_level = DW'(500);
      i_trig_rising   = 1'b1;
      i_arm = 1'b1;
      tick();
      i_arm = 1'b0;
      for (int k = 0; k < 20; k++) send(0, 1);
      check("armed_before_abort", int'(o_armed), 1);
      i_abort = 1'b1;
      i_arm   = 1'b1;
      tick();
      i_abort = 1'b0;
      i_arm   = 1'b0;
      check("abort_armed_off", int'(o_armed), 0);
      for (int k = 0; k < 20; k++) send(600 * (k % 2), 1);
      check("abort_stays_idle", int'(o_armed), 0);
      check("abort_no_trigger", int'(or_triggered), 0);

      // Asynchronous reset in POST clears outputs without a clock edge.
      i_arm = 1'b1;
      tick();
      i_arm = 1'b0;
      for (int k = 0; k < 60; k++) send(gen(0, k), 1);
      check("post_triggered", int'(or_triggered), 1);
      rstn = 1'b0;
      #1;
      check("arst_triggered",  int'(or_triggered),   0);
      check("arst_done",       int'(or_done),        0);
      check("arst_trig_index", int'(or7_trig_index), 0);
      check("arst_rd_data",    int'(os14_rd_data),   0);
      #2 rstn = 1'b1;
      tick();
      for (int k = 0; k < 40; k++) send(gen(0, k), 1);
      check("arst_no_rearm", int'(o_armed), 0);
      check("arst_no_trig",  int'(or_triggered), 0);

      run_capture(vecs[0], "rearm");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
